// File: rtl/bus_arbiter.sv
// bus_arbiter: single-owner bus arbiter with turnaround cycle and hold timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic                           slave_busy,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           bus_util,
  output logic                           timeout_pulse
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [15:0] TMAX = TIMEOUT_CYCLES - 16'd1;
  typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;
  state_t state_q;
  logic [NUM_MASTERS-1:0] grant_q, mask_q, elig;
  logic [IW-1:0] grant_id_q, win;
  logic [15:0] timer_q, timer_d;
  logic bus_util_q, timeout_pulse_q, arm_q, found;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  int idx;
`endif
  assign grant = grant_q;
  assign grant_id = grant_id_q;
  assign bus_util = bus_util_q;
  assign timeout_pulse = timeout_pulse_q;
  assign elig = req & ~mask_q;
  assign timer_d = (&timer_q) ? timer_q : timer_q + 16'd1;
  // Descending scan so the last hit is the highest-priority candidate.
  always_comb begin
    found = 1'b0;
    win = '0;
`ifdef ARB_ROUND_ROBIN_EN
    idx = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + 1 + k) % NUM_MASTERS;
      if (elig[idx]) begin
        found = 1'b1;
        win = IW'(idx);
      end
    end
`else
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (elig[k]) begin
        found = 1'b1;
        win = IW'(k);
      end
    end
`endif
  end
  // arm_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_id_q <= '0;
      bus_util_q <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timer_q <= '0;
      mask_q <= '0;
      arm_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q <= IW'(NUM_MASTERS - 1);
`endif
    end else begin
      arm_q <= 1'b1;
      mask_q <= mask_q & req;
      timeout_pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (arm_q && !slave_busy && found) begin
          state_q <= OWNED;
          grant_q <= NUM_MASTERS'(1) << win;
          grant_id_q <= win;
          bus_util_q <= 1'b1;
          timer_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_q <= win;
`endif
        end
        OWNED: begin
          timer_q <= timer_d;
          if (!req[grant_id_q] || timer_q == TMAX) begin
            state_q <= RELEASE;
            grant_q <= '0;
            grant_id_q <= '0;
            bus_util_q <= 1'b0;
          end
          if (req[grant_id_q] && timer_q == TMAX) begin
            timeout_pulse_q <= 1'b1;
            mask_q <= (mask_q & req) | grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a behavioural model.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int TO = 1024;
  logic clk, rstn, slave_busy, bus_util, timeout_pulse;
  logic [N-1:0] req, grant, prev_grant;
  logic [1:0] grant_id;
  int n_chk = 0, n_fail = 0, cnt;
  int m_owner, m_hold, m_last, m_w;
  bit m_rel, m_arm, m_pulse;
  logic [N-1:0] m_mask, m_nm;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16'(TO))) dut (
    .clk(clk), .rstn(rstn), .req(req), .slave_busy(slave_busy), .grant(grant),
    .grant_id(grant_id), .bus_util(bus_util), .timeout_pulse(timeout_pulse)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int pick(logic [N-1:0] e);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (e[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int k = 0; k < N; k++) if (e[k]) return k;
`endif
    return -1;
  endfunction

  // Model: who owns the bus, how long it has held it, and the turnaround gap.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_owner = -1; m_hold = 0; m_last = N - 1; m_rel = 0; m_arm = 0; m_pulse = 0; m_mask = '0;
    end else begin
      m_nm = m_mask & req;
      m_pulse = 0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_owner = -1; m_rel = 1;
        end else if (m_hold == TO - 1) begin
          m_nm[m_owner] = 1'b1; m_pulse = 1; m_owner = -1; m_rel = 1;
        end else m_hold = (m_hold < 65535) ? m_hold + 1 : m_hold;
      end else if (m_rel) m_rel = 0;
      else if (m_arm && !slave_busy) begin
        m_w = pick(req & ~m_mask);
        if (m_w >= 0) begin
          m_owner = m_w; m_hold = 0; m_last = m_w;
        end
      end
      m_mask = m_nm;
      m_arm = 1;
    end
  end

  initial prev_grant = '0;
  always @(posedge clk) begin
    #2;
    chk("grant", grant, m_owner >= 0 ? 4'b0001 << m_owner : 4'b0000);
    chk("grant_id", grant_id, m_owner >= 0 ? m_owner : 0);
    chk("bus_util", bus_util, m_owner >= 0);
    chk("timeout_pulse", timeout_pulse, m_pulse);
    chk("onehot0", $onehot0(grant), 1);
    chk("util_eq_or", bus_util, |grant);
    if (rstn && prev_grant != 0 && grant != 0) chk("no_preempt", grant, prev_grant);
    prev_grant = grant;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0; req = '0; slave_busy = 0;
    cyc(2);
    chk("rst_grant", grant, 0);
    chk("rst_util", bus_util, 0);
    rstn = 1; req = 4'b0110;
    cyc(1); chk("arm_delay", grant, 0);
    cyc(1); chk("first_grant", grant, 4'b0010);
    chk("first_id", grant_id, 1);
    chk("first_util", bus_util, 1);
    req = 4'b0100;
    cyc(1); chk("release_gap", grant, 0);
    cyc(1); chk("idle_gap", grant, 0);
    cyc(1); chk("second_grant", grant, 4'b0100);
    req = '0; cyc(3);
    for (int i = 0; i < 4; i++) begin
      req = 4'b0011; cyc(1);
`ifdef ARB_ROUND_ROBIN_EN
      chk("alternate", grant, (i % 2 == 0) ? 4'b0001 : 4'b0010);
`else
      chk("alternate", grant, 4'b0001);
`endif
      req = '0; cyc(3);
    end
    req = 4'b0001; cyc(1);
    chk("to_grant", grant, 4'b0001);
    cnt = 1;
    while (grant[0] && cnt < 1100) begin
      cyc(1);
      if (grant[0]) cnt++;
    end
    chk("hold_cycles", cnt, TO);
    chk("pulse_hi", timeout_pulse, 1);
    cyc(1); chk("pulse_lo", timeout_pulse, 0);
    cyc(8); chk("masked", grant, 0);
    req = '0; cyc(1);
    req = 4'b0001; cyc(1);
    chk("unmasked", grant, 4'b0001);
    req = '0; cyc(3);
    slave_busy = 1; req = 4'b1000;
    cyc(5); chk("busy_block", grant, 0);
    slave_busy = 0;
    cyc(1); chk("busy_free", grant, 4'b1000);
    chk("busy_id", grant_id, 3);
    cyc(2);
    rstn = 0; #1;
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_util", bus_util, 0);
    chk("rst_mid_pulse", timeout_pulse, 0);
    cyc(1); rstn = 1;
    cyc(1); chk("rst_arm", grant, 0);
    cyc(1); chk("rst_regrant", grant, 4'b1000);
    req = '0; cyc(3);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      slave_busy = ($urandom_range(0, 4) == 0);
      rstn = ($urandom_range(0, 2999) != 0);
    end
    rstn = 1; req = '0; cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
